// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and helpers for the memory access unit.
//   state_e   - access FSM states (IDLE, ACCESS, DONE)
//   op_e      - latched operation (OP_READ, OP_WRITE)
//   WAIT_W    - width of the wait-state counter
//   fill_ones - all-ones pattern of a given width, used for the timeout read fill
package mem_access_pkg;

  localparam int unsigned WAIT_W     = 8;
  localparam int unsigned FILL_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Low 'width' bits set; callers cast down to their data width.
  function automatic logic [FILL_MAX_W-1:0] fill_ones(input int unsigned width);
    logic [FILL_MAX_W-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < FILL_MAX_W; i++) begin
      if (i < width) res[i] = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_access_unit_down_counter.sv
// down_counter: loadable counter with enable and zero flag.
//   UP=0: counts down while enabled and saturates at zero.
//   UP=1: counts up while enabled (wraps at 2**WIDTH).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (count -> 0)
//   load, load_val    synchronous load, takes priority over en
//   en                count enable
//   count             current value
//   zero              count == 0
module down_counter
  import mem_access_pkg::*;
#(
  parameter int unsigned WIDTH = WAIT_W,
  parameter bit          UP    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      if (UP) begin
        count <= count + WIDTH'(1);
      end else if (count != '0) begin
        count <= count - WIDTH'(1);
      end
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: owns MAR/MDR and runs a request/ready handshake to the RAM/IO controller.
// Reads and writes are started from IDLE with Rd_Req/Wr_Req (read wins if both), held in
// ACCESS for at least WAIT_CYCLES cycles until Mem_Ready, then report Done for one cycle.
// Optional feature (macro MEM_ACCESS_TIMEOUT_EN): abort an access after TIMEOUT cycles in
// ACCESS with Err and Done together; a timed-out read fills MDR with all-ones.
// Ports:
//   Clk, Reset              clock, asynchronous active-low reset
//   Bus_In, LD_MAR, LD_MDR  CPU bus data and register loads (honoured in IDLE only)
//   Rd_Req, Wr_Req          access requests (accepted in IDLE only, never queued)
//   MAR, MDR                register contents
//   Busy, Done, Err         status: not idle, completion pulse, timeout pulse
//   Mem_Addr, Mem_WData     memory address/write data (mirror MAR/MDR)
//   Mem_CE, Mem_WE          access strobe and write qualifier
//   Mem_RData, Mem_Ready    memory read data and completion
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] Bus_In,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              Rd_Req,
  input  logic              Wr_Req,
  output logic [ADDR_W-1:0] MAR,
  output logic [DATA_W-1:0] MDR,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  output logic              Mem_CE,
  output logic              Mem_WE,
  input  logic [DATA_W-1:0] Mem_RData,
  input  logic              Mem_Ready
);

  localparam int unsigned CP_W = (ADDR_W < DATA_W) ? ADDR_W : DATA_W;

  state_e            state;
  op_e               op;
  logic [ADDR_W-1:0] bus_addr;
  logic              start;
  logic [WAIT_W-1:0] wait_count;
  logic              wait_zero;

  // Low bus bits into MAR; zero-extended when the address is wider than the bus.
  always_comb begin
    bus_addr           = '0;
    bus_addr[CP_W-1:0] = Bus_In[CP_W-1:0];
  end

  assign start = (state == IDLE) && (Rd_Req || Wr_Req);

  down_counter #(
    .WIDTH (WAIT_W),
    .UP    (1'b0)
  ) u_wait_cnt (
    .clk      (Clk),
    .rst_n    (Reset),
    .load     (start),
    .load_val (WAIT_W'(WAIT_CYCLES)),
    .en       (state == ACCESS),
    .count    (wait_count),
    .zero     (wait_zero)
  );

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_count;
  logic            to_zero;
  logic            to_hit;

  down_counter #(
    .WIDTH (TO_W),
    .UP    (1'b1)
  ) u_timeout_cnt (
    .clk      (Clk),
    .rst_n    (Reset),
    .load     (start),
    .load_val ('0),
    .en       (state == ACCESS),
    .count    (to_count),
    .zero     (to_zero)
  );

  // Counter is 0 in the first ACCESS cycle, so TIMEOUT-1 marks the last allowed cycle.
  assign to_hit = (to_count == TO_W'(TIMEOUT - 1));
`else
  assign Err = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      op     <= OP_READ;
      MAR    <= '0;
      MDR    <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Mem_CE <= 1'b0;
      Mem_WE <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      Err    <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      Err  <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          // Loads land before the access starts, so a same-cycle request uses the new values.
          if (LD_MAR) MAR <= bus_addr;
          if (LD_MDR) MDR <= Bus_In;
          if (Rd_Req || Wr_Req) begin
            state  <= ACCESS;
            op     <= Rd_Req ? OP_READ : OP_WRITE;
            Busy   <= 1'b1;
            Mem_CE <= 1'b1;
            Mem_WE <= !Rd_Req;
          end
        end
        ACCESS: begin
          if (wait_zero && Mem_Ready) begin
            state  <= DONE;
            Done   <= 1'b1;
            Mem_CE <= 1'b0;
            Mem_WE <= 1'b0;
            if (op == OP_READ) MDR <= Mem_RData;
          end
`ifdef MEM_ACCESS_TIMEOUT_EN
          else if (to_hit) begin
            state  <= DONE;
            Done   <= 1'b1;
            Err    <= 1'b1;
            Mem_CE <= 1'b0;
            Mem_WE <= 1'b0;
            if (op == OP_READ) MDR <= DATA_W'(fill_ones(DATA_W));
          end
`endif
        end
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign Mem_Addr  = MAR;
  assign Mem_WData = MDR;

  // Every completed access drains the wait counter, so IDLE always sees it at zero.
  a_idle_wait_clear: assert property (@(posedge Clk) disable iff (!Reset)
                                      (state == IDLE) |-> (wait_count == '0));
  a_timeout_cfg: assert property (@(posedge Clk) TIMEOUT > WAIT_CYCLES);

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int W  = 2;
  localparam int TO = 20;

  logic        clk;
  logic        reset_n;
  logic [15:0] bus_in;
  logic        ld_mar, ld_mdr, rd_req, wr_req;
  logic [15:0] mar, mdr, mem_addr, mem_wdata, mem_rdata;
  logic        busy, done, err, mem_ce, mem_we, mem_ready;

  mem_access_unit #(
    .DATA_W      (16),
    .ADDR_W      (16),
    .WAIT_CYCLES (W),
    .TIMEOUT     (TO)
  ) dut (
    .Clk       (clk),
    .Reset     (reset_n),
    .Bus_In    (bus_in),
    .LD_MAR    (ld_mar),
    .LD_MDR    (ld_mdr),
    .Rd_Req    (rd_req),
    .Wr_Req    (wr_req),
    .MAR       (mar),
    .MDR       (mdr),
    .Busy      (busy),
    .Done      (done),
    .Err       (err),
    .Mem_Addr  (mem_addr),
    .Mem_WData (mem_wdata),
    .Mem_CE    (mem_ce),
    .Mem_WE    (mem_we),
    .Mem_RData (mem_rdata),
    .Mem_Ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction-level model: an access starting in cycle s strobes from s until the cycle e
  // in which it completes (first cycle >= s+W with Ready, or timeout), Done in e+1.
  bit          m_active = 0;
  bit          m_write  = 0;
  bit          m_err    = 0;
  int          m_start  = 0;
  int          m_end    = -1;
  logic [15:0] exp_mar  = '0;
  logic [15:0] exp_mdr  = '0;

  // Observation log for the literal checks.
  int ce_first, ce_last, ce_cnt, we_cnt, done_first, done_cyc, done_cnt, err_cnt, err_cyc;
  logic [15:0] ce_addr, ce_wdata;

  task automatic clr_mon();
    ce_first = -1; ce_last = -1; ce_cnt = 0; we_cnt = 0;
    done_first = -1; done_cyc = -1; done_cnt = 0; err_cnt = 0; err_cyc = -1;
    ce_addr = '0; ce_wdata = '0;
  endtask

  always @(negedge clk) begin
    bit acc, dn;
    if (!reset_n) begin
      chk("rst_busy", busy, 1'b0);
      chk("rst_ce", mem_ce, 1'b0);
      chk("rst_we", mem_we, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_mar", mar, 16'h0);
      chk("rst_mdr", mdr, 16'h0);
      m_active = 0; m_end = -1; m_err = 0; exp_mar = '0; exp_mdr = '0;
    end else begin
      acc = m_active && (m_end < 0 || cyc <= m_end);
      dn  = m_active && m_end >= 0 && cyc == m_end + 1;
      chk("busy", busy, acc || dn);
      chk("mem_ce", mem_ce, acc);
      chk("mem_we", mem_we, acc && m_write);
      chk("done", done, dn);
      chk("err", err, dn && m_err);
      chk("mar", mar, exp_mar);
      chk("mdr", mdr, exp_mdr);
      chk("mem_addr", mem_addr, exp_mar);
      chk("mem_wdata", mem_wdata, exp_mdr);
      if (!m_active) begin
        if (ld_mar) exp_mar = bus_in;
        if (ld_mdr) exp_mdr = bus_in;
        if (rd_req || wr_req) begin
          m_active = 1; m_start = cyc + 1; m_end = -1; m_write = !rd_req; m_err = 0;
        end
      end else if (acc) begin
        if (cyc >= m_start + W && mem_ready) begin
          m_end = cyc;
          if (!m_write) exp_mdr = mem_rdata;
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        else if (cyc == m_start + TO - 1) begin
          m_end = cyc; m_err = 1;
          if (!m_write) exp_mdr = 16'hFFFF;
        end
`endif
      end else begin
        m_active = 0;
      end
    end
    if (mem_ce) begin
      if (ce_first < 0) ce_first = cyc;
      ce_last = cyc; ce_cnt++; ce_addr = mem_addr; ce_wdata = mem_wdata;
      if (mem_we) we_cnt++;
    end
    if (done) begin
      if (done_first < 0) done_first = cyc;
      done_cyc = cyc; done_cnt++;
    end
    if (err) begin
      err_cnt++; err_cyc = cyc;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int i = 0;
    while (busy && i < maxc) begin
      step();
      i++;
    end
    chk(nm, busy, 1'b0);
  endtask

  initial begin
    int c0;
    reset_n = 0; bus_in = '0; ld_mar = 0; ld_mdr = 0; rd_req = 0; wr_req = 0;
    mem_rdata = '0; mem_ready = 0;
    clr_mon();
    repeat (3) step();
    reset_n = 1;
    step();

    // T1: read at 0x3000 with Ready always high
    bus_in = 16'h3000; ld_mar = 1; step(); ld_mar = 0;
    mem_ready = 1; mem_rdata = 16'hBEEF; rd_req = 1; clr_mon(); c0 = cyc; step(); rd_req = 0;
    wait_idle(20, "t1_bound");
    chk("t1_ce_first", ce_first - c0, 1);
    chk("t1_ce_last", ce_last - c0, 3);
    chk("t1_done_cyc", done_cyc - c0, 4);
    chk("t1_mdr", mdr, 16'hBEEF);
    chk("t1_we_cnt", we_cnt, 0);

    // T2: write, new MDR loaded in the request cycle
    bus_in = 16'h0042; ld_mar = 1; step(); ld_mar = 0;
    bus_in = 16'h1234; ld_mdr = 1; wr_req = 1; clr_mon(); c0 = cyc; step();
    ld_mdr = 0; wr_req = 0; bus_in = 16'hDEAD;
    wait_idle(20, "t2_bound");
    chk("t2_done_cyc", done_cyc - c0, 4);
    chk("t2_we_cnt", we_cnt, 3);
    chk("t2_addr", ce_addr, 16'h0042);
    chk("t2_wdata", ce_wdata, 16'h1234);

    // T3: LD_MAR with Rd_Req, early Ready pulse ignored, LD_MAR mid-access ignored
    mem_ready = 0; mem_rdata = 16'h5A5A; bus_in = 16'h0077; ld_mar = 1; rd_req = 1;
    clr_mon(); c0 = cyc; step(); ld_mar = 0; rd_req = 0;
    step();                                   // c0+2: wait count is 1
    mem_ready = 1; step(); mem_ready = 0;      // c0+3
    step();                                   // c0+4
    bus_in = 16'hFFFF; ld_mar = 1; step(); ld_mar = 0;  // c0+5
    repeat (7) step();                        // c0+12
    mem_ready = 1;
    wait_idle(20, "t3_bound");
    chk("t3_done_cyc", done_cyc - c0, 13);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_mdr", mdr, 16'h5A5A);
    chk("t3_mar", mar, 16'h0077);

    // T4: Rd+Wr together reads; Rd held through the access, re-accepted only at c0+5
    bus_in = 16'h0000; ld_mdr = 1; step(); ld_mdr = 0;
    mem_rdata = 16'hC3C3; rd_req = 1; wr_req = 1; clr_mon(); c0 = cyc; step(); wr_req = 0;
    repeat (5) step();
    rd_req = 0;
    wait_idle(20, "t4_bound");
    chk("t4_done_first", done_first - c0, 4);
    chk("t4_done_last", done_cyc - c0, 9);
    chk("t4_done_cnt", done_cnt, 2);
    chk("t4_we_cnt", we_cnt, 0);
    chk("t4_mdr", mdr, 16'hC3C3);

    // T5: asynchronous reset in cycle 2 of an access
    mem_ready = 0; rd_req = 1; c0 = cyc; step(); rd_req = 0;
    step();
    #1 reset_n = 0;
    #1;
    chk("t5_ce", mem_ce, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", done, 1'b0);
    chk("t5_mar", mar, 16'h0);
    chk("t5_mdr", mdr, 16'h0);
    step();
    reset_n = 1; mem_ready = 1; clr_mon();
    repeat (8) step();
    chk("t5_done_after", done_cnt, 0);
    chk("t5_ce_after", ce_cnt, 0);

    // T6: Ready never comes
    mem_ready = 0; rd_req = 1; clr_mon(); c0 = cyc; step(); rd_req = 0;
`ifdef MEM_ACCESS_TIMEOUT_EN
    wait_idle(40, "t6_bound");
    chk("t6_done_cyc", done_cyc - c0, 21);
    chk("t6_err_cyc", err_cyc - c0, 21);
    chk("t6_err_cnt", err_cnt, 1);
    chk("t6_mdr", mdr, 16'hFFFF);
`else
    repeat (40) step();
    chk("t6_busy", busy, 1'b1);
    chk("t6_done_cnt", done_cnt, 0);
    chk("t6_err_cnt", err_cnt, 0);
    reset_n = 0; step(); reset_n = 1; step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
